// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package : vga_pkg
// Purpose : shared widths and serializer state encoding for the glyph path
// Rev     : 1.0
// ============================================================================
package vga_pkg;

  localparam int GLYPH_W = 8;
  localparam int ROW_W   = 4;
  localparam int CHAR_W  = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_SHIFT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pixel_shift_reg.sv
`default_nettype none
// ============================================================================
// Module  : pixel_shift_reg
// Purpose : 8-bit glyph load/shift register with per-pixel repeat count
// Rev     : 1.0
// ============================================================================
module pixel_shift_reg
  import vga_pkg::*;
#(
  parameter int PIXEL_REPEAT = 1,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic [GLYPH_W-1:0] loadByte_i,
  input  logic               advance_i,
  output logic               pixelOut_o,
  output logic               lastPixel_o
);

  localparam int REP_W = (PIXEL_REPEAT > 1) ? $clog2(PIXEL_REPEAT) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(PIXEL_REPEAT - 1);

  logic [GLYPH_W-1:0] data_q, data_d;
  logic [2:0]         idx_q, idx_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic               repDone;

  assign repDone = (rep_q == REP_LAST);

  // Load wins over advance so a back-to-back reload lands on the final pixel edge.
  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    rep_d  = rep_q;
    if (load_i) begin
      data_d = loadByte_i;
      idx_d  = 3'd0;
      rep_d  = '0;
    end else if (advance_i) begin
      if (repDone) begin
        rep_d  = '0;
        idx_d  = idx_q + 3'd1;
        data_d = MSB_FIRST ? {data_q[GLYPH_W-2:0], 1'b0} : {1'b0, data_q[GLYPH_W-1:1]};
      end else begin
        rep_d = rep_q + REP_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= '0;
      idx_q  <= 3'd0;
      rep_q  <= '0;
    end else begin
      data_q <= data_d;
      idx_q  <= idx_d;
      rep_q  <= rep_d;
    end
  end

  assign pixelOut_o  = MSB_FIRST ? data_q[GLYPH_W-1] : data_q[0];
  assign lastPixel_o = (idx_q == 3'd7) && repDone;

endmodule
`default_nettype wire

// File: rtl/glyph_pixel_serializer.sv
`default_nettype none
// ============================================================================
// Module  : glyph_pixel_serializer
// Purpose : fetches one glyph row per character cell and streams it as pixels
// Rev     : 1.0
// ============================================================================
module glyph_pixel_serializer
  import vga_pkg::*;
#(
  parameter int PIXEL_REPEAT = 1,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CHAR_W-1:0]  charIndex,
  input  logic [ROW_W-1:0]   rowIndex,
  input  logic [GLYPH_W-1:0] romByte,
  output logic               romEnable,
  output logic [CHAR_W-1:0]  highAddrOffset,
  output logic [ROW_W-1:0]   lowAddrOffset,
  output logic               pixelOut,
  output logic               pixelValid,
  output logic               busy,
  output logic               cellDone,
  output logic               startOverrun
);

  logic [1:0]         state_q, state_d;
  logic               pending_q, pending_d;
  logic               romEnable_q, romEnable_d;
  logic [CHAR_W-1:0]  highAddr_q, highAddr_d;
  logic [ROW_W-1:0]   lowAddr_q, lowAddr_d;
  logic               overrun_q, overrun_d;
  logic               ready_q, ready_d;
  logic               fetched_q;
  logic               blank_q;
  logic [GLYPH_W-1:0] byte_q;

  logic               load;
  logic [GLYPH_W-1:0] loadByte;
  logic               shiftPixel;
  logic               lastPixel;
  logic               inShift;
  logic               cellEnd;

  assign inShift  = (state_q == S_SHIFT);
  assign cellEnd  = inShift && lastPixel;
  // A byte captured earlier is preferred; otherwise the ROM is delivering it this cycle.
  assign loadByte = blank_q ? '0 : (ready_q ? byte_q : romByte);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    romEnable_d = 1'b0;
    highAddr_d  = highAddr_q;
    lowAddr_d   = lowAddr_q;
    overrun_d   = 1'b0;
    ready_d     = ready_q | fetched_q;
    load        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          romEnable_d = 1'b1;
          highAddr_d  = charIndex;
          lowAddr_d   = rowIndex;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        overrun_d = start;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        overrun_d = start;
        load      = 1'b1;
        ready_d   = 1'b0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (start) begin
          if (pending_q) begin
            overrun_d = 1'b1;
          end else begin
            romEnable_d = 1'b1;
            highAddr_d  = charIndex;
            lowAddr_d   = rowIndex;
            if (!cellEnd) pending_d = 1'b1;
          end
        end
        if (cellEnd) begin
          if (pending_q && ready_q) begin
            load      = 1'b1;
            ready_d   = 1'b0;
            pending_d = 1'b0;
          end else if (pending_q) begin
            pending_d = 1'b0;
            state_d   = S_LOAD;
          end else if (start) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      romEnable_q <= 1'b0;
      highAddr_q  <= '0;
      lowAddr_q   <= '0;
      overrun_q   <= 1'b0;
      ready_q     <= 1'b0;
      fetched_q   <= 1'b0;
      blank_q     <= 1'b0;
      byte_q      <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      romEnable_q <= romEnable_d;
      highAddr_q  <= highAddr_d;
      lowAddr_q   <= lowAddr_d;
      overrun_q   <= overrun_d;
      ready_q     <= ready_d;
      fetched_q   <= romEnable_q;
      if (romEnable_q) blank_q <= highAddr_q[CHAR_W-1];
      if (fetched_q) byte_q <= romByte;
    end
  end

  pixel_shift_reg #(
    .PIXEL_REPEAT (PIXEL_REPEAT),
    .MSB_FIRST    (MSB_FIRST)
  ) u_shift (
    .clock       (clock),
    .reset       (reset),
    .load_i      (load),
    .loadByte_i  (loadByte),
    .advance_i   (inShift),
    .pixelOut_o  (shiftPixel),
    .lastPixel_o (lastPixel)
  );

  assign romEnable      = romEnable_q;
  assign highAddrOffset = highAddr_q;
  assign lowAddrOffset  = lowAddr_q;
  assign pixelValid     = inShift;
  assign pixelOut       = inShift && shiftPixel;
  assign busy           = (state_q != S_IDLE);
  assign cellDone       = cellEnd;
  assign startOverrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_glyph_pixel_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_glyph_pixel_serializer
// Purpose : directed self-checking bench for glyph_pixel_serializer
// Rev     : 1.0
// ============================================================================
module tb_glyph_pixel_serializer;

  logic       clock = 1'b0;
  logic       reset1, start1, reset2, start2;
  logic [2:0] charIndex1, charIndex2;
  logic [3:0] rowIndex1, rowIndex2;
  logic [7:0] romByte1 = 8'h00;
  logic [7:0] romByte2 = 8'h00;
  logic       romEnable1, pixelOut1, pixelValid1, busy1, cellDone1, startOverrun1;
  logic       romEnable2, pixelOut2, pixelValid2, busy2, cellDone2, startOverrun2;
  logic [2:0] highAddrOffset1, highAddrOffset2;
  logic [3:0] lowAddrOffset1, lowAddrOffset2;

  int checks = 0;
  int errors = 0;
  int romCnt1 = 0;
  int cntBase;

  always #5 clock = ~clock;

  glyph_pixel_serializer #(.PIXEL_REPEAT(1), .MSB_FIRST(1'b1)) dut1 (
    .clock(clock), .reset(reset1), .start(start1), .charIndex(charIndex1),
    .rowIndex(rowIndex1), .romByte(romByte1), .romEnable(romEnable1),
    .highAddrOffset(highAddrOffset1), .lowAddrOffset(lowAddrOffset1),
    .pixelOut(pixelOut1), .pixelValid(pixelValid1), .busy(busy1),
    .cellDone(cellDone1), .startOverrun(startOverrun1)
  );

  glyph_pixel_serializer #(.PIXEL_REPEAT(2), .MSB_FIRST(1'b0)) dut2 (
    .clock(clock), .reset(reset2), .start(start2), .charIndex(charIndex2),
    .rowIndex(rowIndex2), .romByte(romByte2), .romEnable(romEnable2),
    .highAddrOffset(highAddrOffset2), .lowAddrOffset(lowAddrOffset2),
    .pixelOut(pixelOut2), .pixelValid(pixelValid2), .busy(busy2),
    .cellDone(cellDone2), .startOverrun(startOverrun2)
  );

  function automatic logic [7:0] rom_data(input logic [2:0] c, input logic [3:0] r);
    case ({c, r})
      7'h15:   return 8'hA5;
      7'h23:   return 8'h3C;
      7'h30:   return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  // Registered ROM controller: blank reads return junk (FF) which must be ignored.
  always @(posedge clock) begin
    if (romEnable1) romByte1 <= highAddrOffset1[2] ? 8'hFF : rom_data(highAddrOffset1, lowAddrOffset1);
    if (romEnable2) romByte2 <= highAddrOffset2[2] ? 8'hFF : rom_data(highAddrOffset2, lowAddrOffset2);
    if (romEnable1) romCnt1 <= romCnt1 + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_cell1(input logic [2:0] c, input logic [3:0] r, input logic dropInFetch);
    start1 = 1'b1; charIndex1 = c; rowIndex1 = r;
    tick();
    chk1("fetch_romEnable", romEnable1, 1'b1);
    chk8("fetch_high", 8'(highAddrOffset1), 8'(c));
    chk8("fetch_low", 8'(lowAddrOffset1), 8'(r));
    chk1("fetch_busy", busy1, 1'b1);
    chk1("fetch_valid", pixelValid1, 1'b0);
    if (dropInFetch) begin
      start1 = 1'b1; charIndex1 = 3'b001; rowIndex1 = 4'h5;
    end
    tick();
    chk1("load_romEnable", romEnable1, 1'b0);
    chk1("load_valid", pixelValid1, 1'b0);
    chk1("load_overrun", startOverrun1, dropInFetch);
    chk8("load_high", 8'(highAddrOffset1), 8'(c));
    tick();
  endtask

  task automatic cell1(input logic [7:0] b,
                       input int sA, input logic [2:0] cA, input logic [3:0] rA,
                       input int sB, input logic [2:0] cB, input logic [3:0] rB);
    for (int i = 0; i < 8; i++) begin
      chk1("cell_valid", pixelValid1, 1'b1);
      chk1("cell_pixel", pixelOut1, b[7-i]);
      chk1("cell_done", cellDone1, i == 7);
      chk1("cell_romEnable", romEnable1, sA >= 0 && i == sA + 1);
      chk1("cell_overrun", startOverrun1, sB >= 0 && i == sB + 1);
      if (i == sA) begin start1 = 1'b1; charIndex1 = cA; rowIndex1 = rA; end
      if (i == sB) begin start1 = 1'b1; charIndex1 = cB; rowIndex1 = rB; end
      if (i < 7) tick();
    end
  endtask

  task automatic idle1(input string tag);
    chk1({tag, "_busy"}, busy1, 1'b0);
    chk1({tag, "_valid"}, pixelValid1, 1'b0);
    chk1({tag, "_pixel"}, pixelOut1, 1'b0);
  endtask

  initial begin
    reset1 = 1'b1; reset2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
    charIndex1 = 3'd0; rowIndex1 = 4'd0; charIndex2 = 3'd0; rowIndex2 = 4'd0;
    repeat (3) tick();
    chk1("rst_romEnable", romEnable1, 1'b0);
    chk1("rst_valid", pixelValid1, 1'b0);
    chk1("rst_busy", busy1, 1'b0);
    chk1("rst_done", cellDone1, 1'b0);
    chk1("rst_overrun", startOverrun1, 1'b0);
    chk8("rst_addr", {1'b0, highAddrOffset1, lowAddrOffset1}, 8'h00);
    chk1("rst2_busy", busy2, 1'b0);
    reset1 = 1'b0; reset2 = 1'b0;

    // Single cell 0xA5, MSB first, then back to idle.
    start_cell1(3'b001, 4'h5, 1'b0);
    cell1(8'hA5, -1, 3'd0, 4'd0, -1, 3'd0, 4'd0);
    tick();
    idle1("t1_idle");

    // Blank cell with ROM returning FF; a start during FETCH is dropped.
    start_cell1(3'b100, 4'h7, 1'b1);
    cell1(8'h00, -1, 3'd0, 4'd0, -1, 3'd0, 4'd0);
    tick();
    idle1("t2_idle");

    // Start on the 2nd pixel: zero-gap handoff.
    cntBase = romCnt1;
    start_cell1(3'b001, 4'h5, 1'b0);
    cell1(8'hA5, 1, 3'b010, 4'h3, -1, 3'd0, 4'd0);
    tick();
    cell1(8'h3C, -1, 3'd0, 4'd0, -1, 3'd0, 4'd0);
    tick();
    idle1("t3_idle");
    chk8("t3_rom_reads", 8'(romCnt1 - cntBase), 8'd2);

    // Start one cycle before cellDone: byte not ready, single gap cycle.
    start_cell1(3'b001, 4'h5, 1'b0);
    cell1(8'hA5, 6, 3'b010, 4'h3, -1, 3'd0, 4'd0);
    tick();
    chk1("t4_gap_valid", pixelValid1, 1'b0);
    chk1("t4_gap_pixel", pixelOut1, 1'b0);
    chk1("t4_gap_busy", busy1, 1'b1);
    tick();
    cell1(8'h3C, -1, 3'd0, 4'd0, -1, 3'd0, 4'd0);
    tick();
    idle1("t4_idle");

    // Start on the cellDone cycle with nothing pending: FETCH+LOAD gap.
    start_cell1(3'b001, 4'h5, 1'b0);
    cell1(8'hA5, 7, 3'b010, 4'h3, -1, 3'd0, 4'd0);
    tick();
    chk1("t4b_fetch_valid", pixelValid1, 1'b0);
    chk1("t4b_fetch_romEnable", romEnable1, 1'b1);
    chk1("t4b_fetch_busy", busy1, 1'b1);
    tick();
    chk1("t4b_load_valid", pixelValid1, 1'b0);
    tick();
    cell1(8'h3C, -1, 3'd0, 4'd0, -1, 3'd0, 4'd0);
    tick();
    idle1("t4b_idle");

    // Two starts in one cell: the second is dropped, address kept.
    cntBase = romCnt1;
    start_cell1(3'b001, 4'h5, 1'b0);
    cell1(8'hA5, 1, 3'b010, 4'h3, 3, 3'b011, 4'h0);
    chk8("t5_addr_kept", {1'b0, highAddrOffset1, lowAddrOffset1}, 8'h23);
    tick();
    cell1(8'h3C, -1, 3'd0, 4'd0, -1, 3'd0, 4'd0);
    tick();
    idle1("t5_idle");
    chk8("t5_rom_reads", 8'(romCnt1 - cntBase), 8'd2);

    // PIXEL_REPEAT=2, LSB first, byte 0x01.
    start2 = 1'b1; charIndex2 = 3'b011; rowIndex2 = 4'h0;
    tick();
    chk1("t6_romEnable", romEnable2, 1'b1);
    tick();
    chk1("t6_load_valid", pixelValid2, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk1("t6_valid", pixelValid2, 1'b1);
      chk1("t6_pixel", pixelOut2, i < 2);
      chk1("t6_done", cellDone2, i == 15);
      if (i < 15) tick();
    end
    tick();
    chk1("t6_idle_busy", busy2, 1'b0);

    // Reset on the 4th pixel cycle aborts the cell.
    start2 = 1'b1; charIndex2 = 3'b011; rowIndex2 = 4'h0;
    tick(); tick(); tick();
    tick(); tick(); tick();
    chk1("t6r_pre_valid", pixelValid2, 1'b1);
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    chk1("t6r_valid", pixelValid2, 1'b0);
    chk1("t6r_pixel", pixelOut2, 1'b0);
    chk1("t6r_busy", busy2, 1'b0);
    chk1("t6r_done", cellDone2, 1'b0);
    chk1("t6r_romEnable", romEnable2, 1'b0);
    chk1("t6r_overrun", startOverrun2, 1'b0);
    chk8("t6r_addr", {1'b0, highAddrOffset2, lowAddrOffset2}, 8'h00);
    start2 = 1'b1; charIndex2 = 3'b011; rowIndex2 = 4'h0;
    tick();
    chk1("t6r_restart_romEnable", romEnable2, 1'b1);
    chk8("t6r_restart_addr", {1'b0, highAddrOffset2, lowAddrOffset2}, 8'h30);
    tick(); tick();
    chk1("t6r_restart_valid", pixelValid2, 1'b1);
    chk1("t6r_restart_pixel0", pixelOut2, 1'b1);
    tick(); tick();
    chk1("t6r_restart_pixel1", pixelOut2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
